qpsk_iq_carrier_gen: RTL and testbench

- Parametrised successor to the single-channel BPSK sine generator.
- Produces synchronous I and Q carrier samples from a shared elaboration-time sine ROM.
- Applies the QPSK phase per accepted 2-bit symbol, with symbol input via valid/ready handshake and seamless back-to-back symbols.
- Sits between the symbol/bit-pairing stage and the DAC/output-combiner stage of the modulator.

---
 rtl/qpsk_pkg.sv | 67 ++++++
 rtl/qpsk_sine_rom.sv | 26 ++
 rtl/qpsk_iq_carrier_gen.sv | 170 +++++++++++++++++
 tb/tb_qpsk_iq_carrier_gen.sv | 363 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/qpsk_pkg.sv
// Shared definitions for the QPSK I/Q carrier generator: symbol type, FSM
// state type, phase-offset helpers and the elaboration-time sine function.
package qpsk_pkg;

    // Incoming 2-bit symbol: i_bit selects the I polarity, q_bit the Q polarity.
    typedef struct packed {
        logic i_bit;
        logic q_bit;
    } sym_t;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    // Phase offsets in table entries; depth is always a multiple of 4.
    function automatic int quarter_off(input int depth);
        return depth / 4;
    endfunction

    function automatic int half_off(input int depth);
        return depth / 2;
    endfunction

    function automatic int three_quarter_off(input int depth);
        return (3 * depth) / 4;
    endfunction

    // round(ampl * sin(2*pi*k/depth)) for k in 0..depth-1. The angle is folded
    // into the first quadrant so a short Taylor series is exact after rounding,
    // and the magnitude is clamped to the largest positive width-bit value.
    function automatic int sine_entry(input int k, input int depth,
                                      input int ampl, input int width);
        real pi_val;
        real x;
        real term;
        real acc;
        int  kk;
        int  sgn;
        int  lim;
        int  r;
        pi_val = 3.14159265358979323846;
        kk     = k;
        sgn    = 1;
        if (kk >= depth / 2) begin
            sgn = -1;
            kk  = kk - depth / 2;
        end
        if (kk > depth / 4) begin
            kk = depth / 2 - kk;
        end
        x    = 2.0 * pi_val * kk / depth;
        term = x;
        acc  = x;
        for (int n = 1; n <= 10; n++) begin
            term = -term * x * x / ((2.0 * n) * (2.0 * n + 1.0));
            acc  = acc + term;
        end
        r   = $rtoi(ampl * acc + 0.5);
        lim = (1 << (width - 1)) - 1;
        if (r > lim) begin
            r = lim;
        end
        return sgn * r;
    endfunction

endpackage

// File: rtl/qpsk_sine_rom.sv
// Sine table with two combinational read ports, shared by the I and Q paths
// so that only one copy of the table exists. Contents fixed at elaboration.
module qpsk_sine_rom
    import qpsk_pkg::*;
#(
    parameter int DATA_W    = 8,
    parameter int LUT_DEPTH = 52,
    parameter int AMPL      = 78
) (
    input  logic [$clog2(LUT_DEPTH)-1:0] addr_a,
    input  logic [$clog2(LUT_DEPTH)-1:0] addr_b,
    output logic signed [DATA_W-1:0]     data_a,
    output logic signed [DATA_W-1:0]     data_b
);

    logic signed [DATA_W-1:0] table_q [LUT_DEPTH];

    for (genvar g = 0; g < LUT_DEPTH; g++) begin : g_rom
        localparam int ENTRY = sine_entry(g, LUT_DEPTH, AMPL, DATA_W);
        assign table_q[g] = DATA_W'(ENTRY);
    end

    assign data_a = table_q[addr_a];
    assign data_b = table_q[addr_b];

endmodule

// File: rtl/qpsk_iq_carrier_gen.sv
// QPSK I/Q carrier generator. Each accepted symbol emits PERIODS_PER_SYM
// carrier periods of I and Q samples with the symbol's phase offsets.
// Optional macro QPSK_SUM_OUT_EN adds the registered I+Q output qpsk_out.
//
// Handshake: a symbol transfers on a rising edge where sym_valid && sym_ready.
// sym_ready is high only with enable high and reset released, either in IDLE
// or during the last sample of the current symbol (seamless back-to-back).
// sym_valid may be withdrawn at any time; sym_bits is ignored without a transfer.
module qpsk_iq_carrier_gen
    import qpsk_pkg::*;
#(
    parameter int DATA_W          = 8,
    parameter int LUT_DEPTH       = 52,
    parameter int AMPL            = 78,
    parameter int PERIODS_PER_SYM = 1
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic                     enable,
    input  logic                     sym_valid,
    input  logic [1:0]               sym_bits,
    output logic                     sym_ready,
    output logic signed [DATA_W-1:0] i_out,
    output logic signed [DATA_W-1:0] q_out,
    output logic                     out_valid,
    output logic                     sym_start
`ifdef QPSK_SUM_OUT_EN
    ,
    output logic signed [DATA_W:0]   qpsk_out
`endif
);

    localparam int AW = $clog2(LUT_DEPTH);
    localparam int PW = (PERIODS_PER_SYM > 1) ? $clog2(PERIODS_PER_SYM) : 1;

    localparam logic [AW-1:0] LAST_IDX  = AW'(LUT_DEPTH - 1);
    localparam logic [PW-1:0] LAST_PER  = PW'(PERIODS_PER_SYM - 1);
    localparam logic [AW:0]   DEPTH_EXT = (AW + 1)'(LUT_DEPTH);
    localparam logic [AW-1:0] OFF_I_POS = '0;
    localparam logic [AW-1:0] OFF_I_NEG = AW'(half_off(LUT_DEPTH));
    localparam logic [AW-1:0] OFF_Q_POS = AW'(quarter_off(LUT_DEPTH));
    localparam logic [AW-1:0] OFF_Q_NEG = AW'(three_quarter_off(LUT_DEPTH));

    state_t        state;
    state_t        state_next;
    logic [AW-1:0] idx;
    logic [PW-1:0] per;
    logic [AW-1:0] off_i;
    logic [AW-1:0] off_q;
    logic [AW:0]   sum_i;
    logic [AW:0]   sum_q;
    logic [AW:0]   wrap_i;
    logic [AW:0]   wrap_q;
    logic [AW-1:0] addr_i;
    logic [AW-1:0] addr_q;
    logic signed [DATA_W-1:0] rom_i;
    logic signed [DATA_W-1:0] rom_q;
    logic          last_sample;
    logic          accept;
    sym_t          sym;

    assign sym         = sym_t'(sym_bits);
    assign last_sample = (state == ST_RUN) && (idx == LAST_IDX) && (per == LAST_PER);
    assign sym_ready   = reset_n && enable && ((state == ST_IDLE) || last_sample);
    assign accept      = sym_valid && sym_ready;

    // Table address = idx + offset, folded back into range with one subtraction.
    always_comb begin
        sum_i  = {1'b0, idx} + {1'b0, off_i};
        sum_q  = {1'b0, idx} + {1'b0, off_q};
        wrap_i = sum_i - DEPTH_EXT;
        wrap_q = sum_q - DEPTH_EXT;
        addr_i = (sum_i >= DEPTH_EXT) ? wrap_i[AW-1:0] : sum_i[AW-1:0];
        addr_q = (sum_q >= DEPTH_EXT) ? wrap_q[AW-1:0] : sum_q[AW-1:0];
    end

    qpsk_sine_rom #(
        .DATA_W   (DATA_W),
        .LUT_DEPTH(LUT_DEPTH),
        .AMPL     (AMPL)
    ) u_rom (
        .addr_a(addr_i),
        .addr_b(addr_q),
        .data_a(rom_i),
        .data_b(rom_q)
    );

    // FSM state register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // FSM next state: a stall freezes the state; the last sample either
    // chains into the next symbol or returns to IDLE.
    always_comb begin
        state_next = state;
        if (enable) begin
            case (state)
                ST_IDLE: if (accept) state_next = ST_RUN;
                ST_RUN:  if (last_sample && !accept) state_next = ST_IDLE;
            endcase
        end
    end

    // Counters, latched offsets and registered sample outputs.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            idx       <= '0;
            per       <= '0;
            off_i     <= '0;
            off_q     <= '0;
            i_out     <= '0;
            q_out     <= '0;
            out_valid <= 1'b0;
            sym_start <= 1'b0;
        end else if (!enable) begin
            out_valid <= 1'b0;
            sym_start <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    i_out     <= '0;
                    q_out     <= '0;
                    out_valid <= 1'b0;
                    sym_start <= 1'b0;
                end
                ST_RUN: begin
                    i_out     <= rom_i;
                    q_out     <= rom_q;
                    out_valid <= 1'b1;
                    sym_start <= (idx == '0) && (per == '0);
                    if (!accept) begin
                        if (idx == LAST_IDX) begin
                            idx <= '0;
                            per <= (per == LAST_PER) ? '0 : per + 1'b1;
                        end else begin
                            idx <= idx + 1'b1;
                        end
                    end
                end
            endcase
            if (accept) begin
                idx   <= '0;
                per   <= '0;
                off_i <= sym.i_bit ? OFF_I_POS : OFF_I_NEG;
                off_q <= sym.q_bit ? OFF_Q_POS : OFF_Q_NEG;
            end
        end
    end

`ifdef QPSK_SUM_OUT_EN
    // Registered I+Q sum, aligned with i_out/q_out and held during a stall.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            qpsk_out <= '0;
        end else if (enable) begin
            if (state == ST_RUN) begin
                qpsk_out <= {rom_i[DATA_W-1], rom_i} + {rom_q[DATA_W-1], rom_q};
            end else begin
                qpsk_out <= '0;
            end
        end
    end
`endif

endmodule

// File: tb/tb_qpsk_iq_carrier_gen.sv
// Self-checking bench for qpsk_iq_carrier_gen: a default-parameter instance
// and a LUT_DEPTH=16 / AMPL=100 / PERIODS_PER_SYM=3 instance. Expected
// samples come from a $sin reference model pushed into per-instance queues.
module tb_qpsk_iq_carrier_gen;

    localparam int LUT   = 52;
    localparam int AMPL  = 78;
    localparam int LUT3  = 16;
    localparam int AMPL3 = 100;
    localparam int PPS3  = 3;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic reset_n;
    logic enable, sym_valid, sym_ready, out_valid, sym_start;
    logic [1:0] sym_bits;
    logic signed [7:0] i_out, q_out;
    logic en3, v3, ready3, ov3, ss3;
    logic [1:0] b3;
    logic signed [7:0] i3, q3;
`ifdef QPSK_SUM_OUT_EN
    logic signed [8:0] qs, qs3;
`endif

    qpsk_iq_carrier_gen dut (
        .clk(clk), .reset_n(reset_n), .enable(enable), .sym_valid(sym_valid),
        .sym_bits(sym_bits), .sym_ready(sym_ready), .i_out(i_out), .q_out(q_out),
        .out_valid(out_valid), .sym_start(sym_start)
`ifdef QPSK_SUM_OUT_EN
        , .qpsk_out(qs)
`endif
    );

    qpsk_iq_carrier_gen #(
        .DATA_W(8), .LUT_DEPTH(LUT3), .AMPL(AMPL3), .PERIODS_PER_SYM(PPS3)
    ) dut3 (
        .clk(clk), .reset_n(reset_n), .enable(en3), .sym_valid(v3),
        .sym_bits(b3), .sym_ready(ready3), .i_out(i3), .q_out(q3),
        .out_valid(ov3), .sym_start(ss3)
`ifdef QPSK_SUM_OUT_EN
        , .qpsk_out(qs3)
`endif
    );

    // ---------------- scoreboard state ----------------
    int checks = 0;
    int errors = 0;
    logic [16:0] exp_q[$];
    logic [16:0] exp3_q[$];
    int valid_cnt, start_cnt, cap_n, run_len, max_run;
    logic signed [7:0] cap_i[256];
    logic signed [7:0] cap_q[256];
    logic cap_s[256];
    int valid3, start3, n3;
    logic signed [7:0] q3_first, i3_s2;
    logic signed [8:0] qs3_s2;

    task automatic chk(input string tag, input logic signed [31:0] obs,
                       input logic signed [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
        end
    endtask

    function automatic int ref_sine(input int k, input int depth, input int ampl);
        real x;
        x = ampl * $sin(2.0 * 3.14159265358979 * k / depth);
        if (x >= 0.0) return $rtoi(x + 0.5);
        return -$rtoi(-x + 0.5);
    endfunction

    // ---------------- driver tasks ----------------
    task automatic push_sym(input logic [1:0] b);
        int oi, oq;
        logic [7:0] ei, eq;
        oi = b[1] ? 0 : LUT / 2;
        oq = b[0] ? LUT / 4 : 3 * LUT / 4;
        for (int k = 0; k < LUT; k++) begin
            ei = 8'(ref_sine((k + oi) % LUT, LUT, AMPL));
            eq = 8'(ref_sine((k + oq) % LUT, LUT, AMPL));
            exp_q.push_back({(k == 0), ei, eq});
        end
    endtask

    task automatic push_sym3(input logic [1:0] b);
        int oi, oq;
        logic [7:0] ei, eq;
        oi = b[1] ? 0 : LUT3 / 2;
        oq = b[0] ? LUT3 / 4 : 3 * LUT3 / 4;
        for (int p = 0; p < PPS3; p++) begin
            for (int k = 0; k < LUT3; k++) begin
                ei = 8'(ref_sine((k + oi) % LUT3, LUT3, AMPL3));
                eq = 8'(ref_sine((k + oq) % LUT3, LUT3, AMPL3));
                exp3_q.push_back({(p == 0 && k == 0), ei, eq});
            end
        end
    endtask

    task automatic clear_counts();
        valid_cnt = 0; start_cnt = 0; cap_n = 0; max_run = 0;
    endtask

    // Waits for sym_ready, then lets one rising edge complete the transfer.
    task automatic wait_accept(input string tag);
        int n;
        n = 0;
        @(negedge clk);
        while (sym_ready !== 1'b1 && n < 300) begin
            @(negedge clk);
            n++;
        end
        if (n >= 300) chk({tag, "_ready_timeout"}, sym_ready, 1);
        @(posedge clk);
        #1;
    endtask

    task automatic send_sym(input logic [1:0] b, input string tag);
        push_sym(b);
        sym_bits  = b;
        sym_valid = 1'b1;
        wait_accept(tag);
        sym_valid = 1'b0;
        sym_bits  = $urandom_range(0, 3);
    endtask

    task automatic wait_samples(input int target, input string tag);
        int n;
        n = 0;
        while (valid_cnt < target && n < 1000) begin
            @(posedge clk);
            n++;
        end
        repeat (3) @(posedge clk);
        #1;
        chk({tag, "_count"}, valid_cnt, target);
        chk({tag, "_drained"}, exp_q.size(), 0);
        chk({tag, "_idle_valid"}, out_valid, 0);
        chk({tag, "_idle_i"}, i_out, 0);
    endtask

    // Advances until the given number of samples has been emitted.
    task automatic run_to_sample(input int count);
        int k, n;
        k = 0;
        n = 0;
        while (k < count && n < 300) begin
            @(posedge clk);
            #1;
            if (out_valid === 1'b1) k++;
            n++;
        end
        if (n >= 300) chk("run_to_sample_timeout", k, count);
    endtask

    // ---------------- scoreboard monitors ----------------
    always @(negedge clk) begin
        logic [16:0] e;
        if (out_valid === 1'b1) begin
            valid_cnt++;
            run_len++;
            if (run_len > max_run) max_run = run_len;
            if (sym_start === 1'b1) start_cnt++;
            if (cap_n < 256) begin
                cap_i[cap_n] = i_out;
                cap_q[cap_n] = q_out;
                cap_s[cap_n] = sym_start;
                cap_n++;
            end
            if (exp_q.size() == 0) begin
                chk("sample_unexpected", out_valid, 0);
            end else begin
                e = exp_q.pop_front();
                chk("sample", {sym_start, i_out, q_out}, e);
`ifdef QPSK_SUM_OUT_EN
                chk("qpsk_sum", qs, $signed(e[15:8]) + $signed(e[7:0]));
`endif
            end
        end else begin
            run_len = 0;
        end
    end

    always @(negedge clk) begin
        logic [16:0] e;
        if (ov3 === 1'b1) begin
            if (ss3 === 1'b1) begin
                start3++;
                n3 = 0;
            end
            if (n3 == 0) q3_first = q3;
            if (n3 == 2) i3_s2 = i3;
`ifdef QPSK_SUM_OUT_EN
            if (n3 == 2) qs3_s2 = qs3;
`endif
            n3++;
            valid3++;
            if (exp3_q.size() == 0) begin
                chk("sample3_unexpected", ov3, 0);
            end else begin
                e = exp3_q.pop_front();
                chk("sample3", {ss3, i3, q3}, e);
            end
        end
    end

    initial begin
        #300000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    // ---------------- directed sequence ----------------
    initial begin
        reset_n = 1'b0; enable = 1'b1; sym_valid = 1'b0; sym_bits = 2'b00;
        en3 = 1'b1; v3 = 1'b0; b3 = 2'b00;
        valid3 = 0; start3 = 0; n3 = 0; run_len = 0;
        clear_counts();
        #12;
        chk("rst_i", i_out, 0);
        chk("rst_q", q_out, 0);
        chk("rst_valid", out_valid, 0);
        chk("rst_ready", sym_ready, 0);
        @(posedge clk); #1;
        reset_n = 1'b1;
        @(negedge clk);
        chk("idle_ready", sym_ready, 1);
        chk("idle_valid", out_valid, 0);

        // Symbol 11
        @(posedge clk); #1;
        clear_counts();
        send_sym(2'b11, "s11");
        wait_samples(52, "s11");
        chk("s11_i0", cap_i[0], 0);
        chk("s11_q0", cap_q[0], 78);
        chk("s11_i1", cap_i[1], 9);
        chk("s11_q1", cap_q[1], 77);
        chk("s11_i13", cap_i[13], 78);
        chk("s11_q13", cap_q[13], 0);
        chk("s11_start0", cap_s[0], 1);
        chk("s11_start1", cap_s[1], 0);
        chk("s11_starts", start_cnt, 1);

        // Symbol 00
        clear_counts();
        send_sym(2'b00, "s00");
        wait_samples(52, "s00");
        chk("s00_i0", cap_i[0], 0);
        chk("s00_q0", cap_q[0], -78);
        chk("s00_i13", cap_i[13], -78);
        chk("s00_q13", cap_q[13], 0);

        // Symbol 10
        clear_counts();
        send_sym(2'b10, "s10");
        wait_samples(52, "s10");
        chk("s10_i0", cap_i[0], 0);
        chk("s10_q0", cap_q[0], -78);

        // Back-to-back 11 then 01 with sym_valid held
        clear_counts();
        push_sym(2'b11);
        sym_bits  = 2'b11;
        sym_valid = 1'b1;
        wait_accept("b2b_first");
        sym_bits = 2'b01;
        push_sym(2'b01);
        wait_accept("b2b_second");
        sym_valid = 1'b0;
        wait_samples(104, "b2b");
        chk("b2b_i51", cap_i[51], -9);
        chk("b2b_i52", cap_i[52], 0);
        chk("b2b_q52", cap_q[52], 78);
        chk("b2b_start52", cap_s[52], 1);
        chk("b2b_i65", cap_i[65], -78);
        chk("b2b_no_gap", max_run, 104);
        chk("b2b_starts", start_cnt, 2);

        // Stall for 5 cycles after sample 20
        clear_counts();
        send_sym(2'b11, "stall");
        run_to_sample(21);
        enable = 1'b0;
        for (int c = 0; c < 5; c++) begin
            @(posedge clk);
            @(negedge clk);
            chk("stall_valid", out_valid, 0);
            chk("stall_ready", sym_ready, 0);
            chk("stall_i", i_out, ref_sine(20, LUT, AMPL));
            chk("stall_q", q_out, ref_sine(33, LUT, AMPL));
        end
        enable = 1'b1;
        wait_samples(52, "stall");
        chk("stall_resume_i21", cap_i[21], ref_sine(21, LUT, AMPL));

        // Asynchronous reset in the middle of sample 30
        clear_counts();
        send_sym(2'b11, "arst");
        run_to_sample(31);
        #2;
        reset_n = 1'b0;
        #1;
        chk("arst_i", i_out, 0);
        chk("arst_q", q_out, 0);
        chk("arst_valid", out_valid, 0);
        chk("arst_ready", sym_ready, 0);
        chk("arst_seen", valid_cnt, 30);
        exp_q.delete();
        @(posedge clk); #1;
        reset_n = 1'b1;
        @(negedge clk);
        chk("arst_idle_ready", sym_ready, 1);
        repeat (3) @(negedge clk);
        chk("arst_idle_valid", out_valid, 0);
        @(posedge clk); #1;
        clear_counts();
        send_sym(2'b01, "post_rst");
        wait_samples(52, "post_rst");
        chk("post_rst_start0", cap_s[0], 1);

        // Three-period, 16-entry instance
        valid3 = 0; start3 = 0; n3 = 0;
        push_sym3(2'b11);
        b3 = 2'b11;
        v3 = 1'b1;
        begin
            int n;
            n = 0;
            @(negedge clk);
            while (ready3 !== 1'b1 && n < 300) begin
                @(negedge clk);
                n++;
            end
            if (n >= 300) chk("p3_ready_timeout", ready3, 1);
            @(posedge clk); #1;
            v3 = 1'b0;
            n = 0;
            while (valid3 < 48 && n < 500) begin
                @(posedge clk);
                n++;
            end
            repeat (3) @(posedge clk);
            #1;
        end
        chk("p3_count", valid3, 48);
        chk("p3_starts", start3, 1);
        chk("p3_q0", q3_first, 100);
        chk("p3_i2", i3_s2, 71);
        chk("p3_drained", exp3_q.size(), 0);
        chk("p3_idle_valid", ov3, 0);
`ifdef QPSK_SUM_OUT_EN
        chk("p3_qsum2", qs3_s2, 142);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
